// File: rtl/snake_engine_if.sv
// Control, food and status bundle for snake_engine.
// The engine takes the slave modport; the game logic driving it takes master.
interface snake_engine_if #(
  parameter int XW = 6,
  parameter int YW = 6,
  parameter int IW = 5,
  parameter int LW = 6
);
  logic          tick;
  logic          start;
  logic          pause_tog;
  logic          dir_valid;
  logic [1:0]    dir_req;
  logic [XW-1:0] food_x;
  logic [YW-1:0] food_y;
  logic [IW-1:0] rd_idx;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          rd_valid;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] len;
  logic [2:0]    state;
  logic          eaten;
  logic          dead;
  logic          overrun;

  modport master (
    output tick, start, pause_tog, dir_valid, dir_req, food_x, food_y, rd_idx,
    input  rd_x, rd_y, rd_valid, head_x, head_y, len, state, eaten, dead, overrun
  );

  modport slave (
    input  tick, start, pause_tog, dir_valid, dir_req, food_x, food_y, rd_idx,
    output rd_x, rd_y, rd_valid, head_x, head_y, len, state, eaten, dead, overrun
  );
endinterface

// File: rtl/snake_engine.sv
// Snake game engine: circular segment buffer, serial self-collision scan per step.
// Define SNAKE_WRAP_EN to wrap at the playfield edges instead of dying there.
module snake_engine #(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 8,
  parameter int INIT_Y   = 8
) (
  input logic          CLK,
  input logic          RST_N,
  snake_engine_if.slave bus
);
  // state | meaning
  // IDLE  | after reset, waiting for start
  // INIT  | writing the initial body, one segment per cycle
  // RUN   | waiting for a tick to step
  // SCAN  | comparing the next head cell against the body
  // PAUSE | frozen, direction requests still accepted
  // DEAD  | game over, waiting for start

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_DEAD  = 3'd5;

  localparam logic [1:0] DIR_R = 2'd0;
  localparam logic [1:0] DIR_L = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;
  localparam logic [1:0] DIR_D = 2'd3;

  localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IW+1)'(MAX_LEN)) s = s - (IW+1)'(MAX_LEN);
    return s[IW-1:0];
  endfunction

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] hp_q, hp_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [IW-1:0] scan_idx_q, scan_idx_d;
  logic [LW-1:0] scan_cnt_q, scan_cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [XW-1:0] head_x_q, head_x_d, nx_q, nx_d, rd_x_q, rd_x_d;
  logic [YW-1:0] head_y_q, head_y_d, ny_q, ny_d, rd_y_q, rd_y_d;
  logic [1:0]    dir_q, dir_d, pend_q, pend_d;
  logic          eat_q, eat_d, eaten_q, eaten_d, dead_q, dead_d;
  logic          overrun_q, overrun_d, rd_valid_q, rd_valid_d;

  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic          we;
  logic [IW-1:0] waddr;
  logic [XW-1:0] wx;
  logic [YW-1:0] wy;

  logic [XW-1:0] step_x;
  logic [YW-1:0] step_y;
  logic          edge_hit, off_grid, food_hit, scan_hit, scan_done, tick_run, opp;
  logic [1:0]    eff_dir;
  logic [IW-1:0] scan_addr, rd_addr, hp_dec;

  always_comb begin
    step_x   = head_x_q;
    step_y   = head_y_q;
    edge_hit = 1'b0;
    unique case (pend_q)
      DIR_R: begin
        edge_hit = (head_x_q == X_MAX);
        step_x   = edge_hit ? '0 : head_x_q + 1'b1;
      end
      DIR_L: begin
        edge_hit = (head_x_q == '0);
        step_x   = edge_hit ? X_MAX : head_x_q - 1'b1;
      end
      DIR_U: begin
        edge_hit = (head_y_q == '0);
        step_y   = edge_hit ? Y_MAX : head_y_q - 1'b1;
      end
      DIR_D: begin
        edge_hit = (head_y_q == Y_MAX);
        step_y   = edge_hit ? '0 : head_y_q + 1'b1;
      end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign off_grid = 1'b0;
`else
  assign off_grid = edge_hit;
`endif

  assign food_hit  = (step_x == bus.food_x) && (step_y == bus.food_y);
  assign scan_addr = wrap_add(hp_q, scan_idx_q);
  assign rd_addr   = wrap_add(hp_q, bus.rd_idx);
  assign hp_dec    = (hp_q == '0) ? IW'(MAX_LEN - 1) : hp_q - 1'b1;
  // The scan covers the vacating tail only when the snake grows this step.
  assign scan_hit  = (LW'(scan_idx_q) < scan_cnt_q) &&
                     (seg_x[scan_addr] == nx_q) && (seg_y[scan_addr] == ny_q);
  assign scan_done = (LW'(scan_idx_q) + LW'(1)) >= scan_cnt_q;
  assign tick_run  = (state_q == S_RUN) && bus.tick && !bus.pause_tog;
  // A request in the tick cycle is judged against the direction being committed.
  assign eff_dir   = tick_run ? pend_q : dir_q;
  assign opp       = (bus.dir_req[1] == eff_dir[1]) && (bus.dir_req[0] != eff_dir[0]);

  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    init_cnt_d = init_cnt_q;
    scan_idx_d = scan_idx_q;
    scan_cnt_d = scan_cnt_q;
    len_d      = len_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    eat_d      = eat_q;
    eaten_d    = 1'b0;
    dead_d     = 1'b0;
    overrun_d  = overrun_q;
    we         = 1'b0;
    waddr      = hp_dec;
    wx         = nx_q;
    wy         = ny_q;
    rd_x_d     = seg_x[rd_addr];
    rd_y_d     = seg_y[rd_addr];
    rd_valid_d = LW'(bus.rd_idx) < len_q;

    if (bus.start && state_q != S_INIT) begin
      state_d    = S_INIT;
      hp_d       = '0;
      init_cnt_d = '0;
      scan_idx_d = '0;
      len_d      = '0;
      head_x_d   = XW'(INIT_X);
      head_y_d   = YW'(INIT_Y);
      dir_d      = DIR_R;
      pend_d     = DIR_R;
      overrun_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          we    = 1'b1;
          waddr = init_cnt_q;
          wx    = XW'(INIT_X) - XW'(init_cnt_q);
          wy    = YW'(INIT_Y);
          if (LW'(init_cnt_q) == LW'(INIT_LEN - 1)) begin
            state_d = S_RUN;
            len_d   = LW'(INIT_LEN);
          end else begin
            init_cnt_d = init_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (bus.pause_tog) begin
            state_d = S_PAUSE;
          end else if (bus.tick) begin
            dir_d = pend_q;
            if (off_grid) begin
              state_d = S_DEAD;
              dead_d  = 1'b1;
            end else begin
              nx_d       = step_x;
              ny_d       = step_y;
              eat_d      = food_hit;
              scan_idx_d = '0;
              scan_cnt_d = food_hit ? len_q : len_q - 1'b1;
              state_d    = S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (bus.tick) overrun_d = 1'b1;
          if (scan_hit) begin
            state_d = S_DEAD;
            dead_d  = 1'b1;
          end else if (scan_done) begin
            we       = 1'b1;
            hp_d     = hp_dec;
            head_x_d = nx_q;
            head_y_d = ny_q;
            state_d  = S_RUN;
            if (eat_q) begin
              eaten_d = 1'b1;
              if (len_q != LEN_MAX) len_d = len_q + 1'b1;
            end
          end else begin
            scan_idx_d = scan_idx_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (bus.pause_tog) state_d = S_RUN;
        end
        S_IDLE, S_DEAD: begin
        end
        default: state_d = S_IDLE;
      endcase
      if ((state_q == S_RUN || state_q == S_PAUSE) && bus.dir_valid && !opp)
        pend_d = bus.dir_req;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      hp_q       <= '0;
      init_cnt_q <= '0;
      scan_idx_q <= '0;
      scan_cnt_q <= '0;
      len_q      <= '0;
      head_x_q   <= '0;
      head_y_q   <= '0;
      nx_q       <= '0;
      ny_q       <= '0;
      dir_q      <= DIR_R;
      pend_q     <= DIR_R;
      eat_q      <= 1'b0;
      eaten_q    <= 1'b0;
      dead_q     <= 1'b0;
      overrun_q  <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      init_cnt_q <= init_cnt_d;
      scan_idx_q <= scan_idx_d;
      scan_cnt_q <= scan_cnt_d;
      len_q      <= len_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      eat_q      <= eat_d;
      eaten_q    <= eaten_d;
      dead_q     <= dead_d;
      overrun_q  <= overrun_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Segment storage carries no reset; len alone decides which entries are live.
  always_ff @(posedge CLK) begin
    if (we) begin
      seg_x[waddr] <= wx;
      seg_y[waddr] <= wy;
    end
  end

  assign bus.state    = state_q;
  assign bus.len      = len_q;
  assign bus.head_x   = head_x_q;
  assign bus.head_y   = head_y_q;
  assign bus.eaten    = eaten_q;
  assign bus.dead     = dead_q;
  assign bus.overrun  = overrun_q;
  assign bus.rd_x     = rd_x_q;
  assign bus.rd_y     = rd_y_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: a queue-based snake model predicts every step outcome.
module tb_snake_engine;
  localparam int GW = 64, GH = 48, ML = 8, IL = 3, IX = 8, IY = 8;
  localparam int XW = 6, YW = 6, IW = 3, LW = 4;
  localparam int ST_IDLE = 0, ST_INIT = 1, ST_RUN = 2, ST_SCAN = 3, ST_PAUSE = 4, ST_DEAD = 5;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  snake_engine_if #(.XW(XW), .YW(YW), .IW(IW), .LW(LW)) bus();

  snake_engine #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL),
                 .INIT_X(IX), .INIT_Y(IY)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  typedef struct {int x; int y;} cell_t;
  typedef struct {bit dead; bit eaten; int hx; int hy; int len;} exp_t;

  cell_t segs[$];
  exp_t  exp_q[$];
  int total = 0, bad = 0;
  int m_len = 0, m_dir = 0, m_pend = 0;
  bit m_run = 0, m_pause = 0;
  int fx = 0, fy = 0;
  int dx[4]  = '{1, -1, 0, 0};
  int dy[4]  = '{0, 0, -1, 1};
  int opp[4] = '{1, 0, 3, 2};

  function automatic void chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endfunction

  function automatic void m_start();
    segs.delete();
    for (int i = 0; i < IL; i++) segs.push_back(cell_t'{x: IX - i, y: IY});
    m_len = IL; m_dir = 0; m_pend = 0; m_run = 1; m_pause = 0;
  endfunction

  function automatic void m_dir_req(input int d);
    if ((m_run || m_pause) && d != opp[m_dir]) m_pend = d;
  endfunction

  function automatic void m_tick();
    int nx, ny, lim;
    bit eat, hit;
    exp_t e;
    if (!m_run) return;
    eat = 0; hit = 0;
    m_dir = m_pend;
    nx = segs[0].x + dx[m_dir];
    ny = segs[0].y + dy[m_dir];
`ifdef SNAKE_WRAP_EN
    nx = (nx + GW) % GW;
    ny = (ny + GH) % GH;
`endif
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) hit = 1;
    else begin
      eat = (nx == fx) && (ny == fy);
      lim = eat ? m_len : m_len - 1;
      for (int i = 0; i < lim; i++)
        if (segs[i].x == nx && segs[i].y == ny) hit = 1;
    end
    if (hit) begin
      e = '{dead: 1'b1, eaten: 1'b0, hx: segs[0].x, hy: segs[0].y, len: m_len};
      m_run = 0;
    end else begin
      segs.push_front(cell_t'{x: nx, y: ny});
      if (eat && m_len < ML) m_len++;
      while (segs.size() > m_len) void'(segs.pop_back());
      e = '{dead: 1'b0, eaten: eat, hx: nx, hy: ny, len: m_len};
    end
    exp_q.push_back(e);
  endfunction

  function automatic int m_state();
    return m_run ? ST_RUN : (m_pause ? ST_PAUSE : ST_DEAD);
  endfunction

  // Step monitor: a completed step (SCAN->RUN) or a dead pulse consumes one prediction.
  int prev_state = ST_IDLE;
  exp_t me;
  always @(negedge CLK) begin
    if (RST_N) begin
      if (bus.dead || (prev_state == ST_SCAN && int'(bus.state) == ST_RUN)) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected step: dead=%0d state=%0d", bus.dead, bus.state);
        end else begin
          me = exp_q.pop_front();
          chk("step dead", int'(bus.dead), int'(me.dead));
          chk("step eaten", int'(bus.eaten), int'(me.eaten));
          chk("step head_x", int'(bus.head_x), me.hx);
          chk("step head_y", int'(bus.head_y), me.hy);
          chk("step len", int'(bus.len), me.len);
          chk("step state", int'(bus.state), me.dead ? ST_DEAD : ST_RUN);
        end
      end
      prev_state = int'(bus.state);
    end
  end

  task automatic set_food(input int x, input int y);
    fx = x; fy = y;
    bus.food_x = x[XW-1:0];
    bus.food_y = y[YW-1:0];
  endtask

  task automatic wait_settle();
    int n = 0;
    while (int'(bus.state) == ST_SCAN && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL scan timeout: state=%0d after %0d cycles", bus.state, n);
    end
  endtask

  task automatic do_tick();
    @(negedge CLK) bus.tick = 1'b1;
    m_tick();
    @(negedge CLK) bus.tick = 1'b0;
    wait_settle();
  endtask

  task automatic do_dir(input int d);
    @(negedge CLK) begin bus.dir_valid = 1'b1; bus.dir_req = 2'(d); end
    m_dir_req(d);
    @(negedge CLK) bus.dir_valid = 1'b0;
  endtask

  task automatic do_pause();
    @(negedge CLK) bus.pause_tog = 1'b1;
    if (m_run) begin m_run = 0; m_pause = 1; end
    else if (m_pause) begin m_run = 1; m_pause = 0; end
    @(negedge CLK) bus.pause_tog = 1'b0;
    chk("pause state", int'(bus.state), m_state());
  endtask

  task automatic wait_run();
    int n = 0;
    while (int'(bus.state) != ST_RUN && n < 40) begin
      @(negedge CLK);
      n++;
    end
    m_start();
    chk("start state", int'(bus.state), ST_RUN);
    chk("start len", int'(bus.len), IL);
  endtask

  task automatic do_start();
    @(negedge CLK) bus.start = 1'b1;
    @(negedge CLK) bus.start = 1'b0;
    wait_run();
  endtask

  task automatic check_segs();
    for (int i = 0; i < ML; i++) begin
      @(negedge CLK) bus.rd_idx = 3'(i);
      @(negedge CLK);
      chk("rd_valid", int'(bus.rd_valid), (i < m_len) ? 1 : 0);
      if (i < m_len) begin
        chk("rd_x", int'(bus.rd_x), segs[i].x);
        chk("rd_y", int'(bus.rd_y), segs[i].y);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, hx, hy, ax, ay;
    bus.tick = 0; bus.start = 0; bus.pause_tog = 0; bus.dir_valid = 0; bus.dir_req = 0;
    bus.rd_idx = 0;
    set_food(0, 0);
    repeat (3) @(negedge CLK);
    chk("reset state", int'(bus.state), ST_IDLE);
    chk("reset len", int'(bus.len), 0);
    chk("reset head_x", int'(bus.head_x), 0);
    chk("reset head_y", int'(bus.head_y), 0);
    chk("reset eaten", int'(bus.eaten), 0);
    chk("reset dead", int'(bus.dead), 0);
    chk("reset overrun", int'(bus.overrun), 0);
    chk("reset rd_valid", int'(bus.rd_valid), 0);
    chk("reset rd_x", int'(bus.rd_x), 0);
    RST_N = 1'b1;

    // Start: three INIT cycles, then RUN with the initial body.
    @(negedge CLK) bus.start = 1'b1;
    @(negedge CLK) bus.start = 1'b0;
    for (int i = 0; i < IL; i++) begin
      chk("init state", int'(bus.state), ST_INIT);
      @(negedge CLK);
    end
    wait_run();
    check_segs();

    // Eat straight ahead.
    set_food(9, 8);
    do_tick();
    check_segs();

    // Reversal into the neck is rejected.
    do_start();
    set_food(0, 0);
    do_dir(1);
    do_tick();

    // Pause freezes stepping but keeps accepting direction.
    do_pause();
    do_tick();
    do_dir(2);
    do_pause();
    do_tick();
    check_segs();

    // Grow to 5, curl back into the body, tick again mid-scan.
    do_start();
    set_food(9, 8);  do_tick();
    set_food(10, 8); do_tick();
    set_food(0, 0);
    do_dir(3); do_tick();
    do_dir(1); do_tick();
    do_dir(2);
    @(negedge CLK) bus.tick = 1'b1;
    m_tick();
    @(negedge CLK);
    @(negedge CLK) bus.tick = 1'b0;
    wait_settle();
    chk("collide state", int'(bus.state), ST_DEAD);
    chk("collide len", int'(bus.len), 5);
    chk("overrun sticky", int'(bus.overrun), 1);
    check_segs();

    // Start and tick together while dead: restart only.
    @(negedge CLK) begin bus.start = 1'b1; bus.tick = 1'b1; end
    @(negedge CLK) begin bus.start = 1'b0; bus.tick = 1'b0; end
    chk("restart state", int'(bus.state), ST_INIT);
    chk("restart overrun", int'(bus.overrun), 0);
    wait_run();
    check_segs();

    // Run to the right edge.
    for (int i = 0; i < GW - 1 - IX; i++) do_tick();
    chk("edge head_x", int'(bus.head_x), GW - 1);
    do_tick();
`ifdef SNAKE_WRAP_EN
    chk("wrap head_x", int'(bus.head_x), 0);
`else
    chk("edge state", int'(bus.state), ST_DEAD);
`endif

    // Randomized play.
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (!m_run && !m_pause) begin
        do_start();
      end else if (r < 10) begin
        set_food($urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
      end else if (r < 55) begin
        hx = segs[0].x; hy = segs[0].y;
        ax = hx + dx[m_pend]; ay = hy + dy[m_pend];
        if ($urandom_range(0, 9) < 4 && ax >= 0 && ax < GW && ay >= 0 && ay < GH)
          set_food(ax, ay);
        do_tick();
      end else if (r < 82) begin
        do_dir($urandom_range(0, 3));
      end else if (r < 88) begin
        do_pause();
      end else if (r < 90) begin
        do_start();
      end
      if (k % 25 == 24) check_segs();
    end
    check_segs();
    chk("scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
